lenet_frame_loader: RTL

- Upstream feeder for the LeNet-5 datapath. Accepts a raster-order stream of 8-bit unsigned MNIST pixels (28x28) with a valid/ready handshake.
- Converts each pixel to signed fixed point and zero-pads the frame to 32x32.
- Presents the result as a flat single-channel vector on frame_vec, with a valid/ready frame handshake toward the network.
- Double-buffered, so frame N+1 streams in while frame N is held stable.

---
 rtl/lenet_pkg.sv | 30 +++
 rtl/frame_bank.sv | 45 ++++
 rtl/lenet_frame_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared types, geometry defaults and the pixel-to-fixed-point conversion
// used by the LeNet-5 frame loader.
package lenet_pkg;

  localparam int IMG_H_DEF = 28;
  localparam int IMG_W_DEF = 28;
  localparam int PAD_DEF   = 2;
  localparam int OUT_DIM   = 32;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  // Unsigned byte -> non-negative fixed point (value = px/256), sign bit kept clear.
  function automatic logic [31:0] pix_to_fixed(input logic [7:0] px, input int width, input int frac);
    logic [31:0] ext;
    logic [31:0] res;
    logic [31:0] mask;
    ext = {24'd0, px};
    if (frac >= 8) begin
      res = ext << (frac - 8);
    end else begin
      res = ext >> (8 - frac);
    end
    mask = (32'd1 << (width - 1)) - 32'd1;
    return res & mask;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One padded frame buffer: DEPTH words of WIDTH bits, async clear, a single
// write port, and the whole contents exposed as one flat vector.
module frame_bank #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [DEPTH*WIDTH-1:0]   data
);

  localparam int IDX_W = $clog2(DEPTH * WIDTH);

  logic [DEPTH*WIDTH-1:0] mem_d;
  logic [DEPTH*WIDTH-1:0] mem_q;
  logic [IDX_W-1:0]       bit_idx;

  assign bit_idx = IDX_W'(waddr) * IDX_W'(WIDTH);

  // Next contents: one word replaced on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[bit_idx +: WIDTH] = wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage; clearing on reset is what keeps the padding border at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign data = mem_q;

endmodule

// File: rtl/lenet_frame_loader.sv
// Streams 28x28 unsigned pixels into one of two zero-padded 32x32 fixed-point
// banks while the other bank is presented to the network as frame_vec.
module lenet_frame_loader
  import lenet_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int IMG_H = IMG_H_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int PAD   = PAD_DEF,
  localparam int OUT_H = IMG_H + 2 * PAD,
  localparam int OUT_W = IMG_W + 2 * PAD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [7:0]                   s_data,
  input  logic                         s_last,
  output logic [OUT_H*OUT_W*WIDTH-1:0] frame_vec,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         err_pulse,
  output logic [7:0]                   drop_cnt
);

  localparam int DEPTH  = OUT_H * OUT_W;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ROW_W  = $clog2(IMG_H);
  localparam int COL_W  = $clog2(IMG_W);

  loader_state_e    state_d, state_q;
  logic [ROW_W-1:0] row_d, row_q;
  logic [COL_W-1:0] col_d, col_q;
  logic             wr_sel_d, wr_sel_q;
  logic             out_sel_d, out_sel_q;
  logic             frame_valid_d, frame_valid_q;
  logic             err_pulse_d, err_pulse_q;
  logic [7:0]       drop_cnt_d, drop_cnt_q;
  logic             s_ready_d, s_ready_q;

  logic                    xfer;
  logic                    last_pix;
  logic                    we0, we1;
  logic [ADDR_W-1:0]       waddr;
  logic [WIDTH-1:0]        wdata;
  logic [DEPTH*WIDTH-1:0]  bank_data0, bank_data1;

  assign xfer     = s_valid && s_ready_q;
  assign last_pix = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      row_q         <= '0;
      col_q         <= '0;
      wr_sel_q      <= 1'b0;
      out_sel_q     <= 1'b1;
      frame_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      drop_cnt_q    <= 8'd0;
      s_ready_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      wr_sel_q      <= wr_sel_d;
      out_sel_q     <= out_sel_d;
      frame_valid_q <= frame_valid_d;
      err_pulse_q   <= err_pulse_d;
      drop_cnt_q    <= drop_cnt_d;
      s_ready_q     <= s_ready_d;
    end
  end

  // Next-state: raster counters, frame completion/drop, and bank swap.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_sel_d    = wr_sel_q;
    out_sel_d   = out_sel_q;
    err_pulse_d = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end

    case (state_q)
      FILL: begin
        if (xfer) begin
          if (s_last && last_pix) begin
            state_d = FULL;
            row_d   = '0;
            col_d   = '0;
          end else if (s_last || last_pix) begin
            // Misaligned frame: count it and resynchronise on the next pixel.
            err_pulse_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
              drop_cnt_d = drop_cnt_q;
            end
            row_d = '0;
            col_d = '0;
          end else if (col_q == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
            row_d = row_q;
          end
        end else begin
          state_d = FILL;
        end
      end
      FULL: begin
        if (!frame_valid_q || frame_ready) begin
          wr_sel_d      = out_sel_q;
          out_sel_d     = wr_sel_q;
          frame_valid_d = 1'b1;
          row_d         = '0;
          col_d         = '0;
          state_d       = FILL;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Outputs: registered s_ready and the bank write port.
  always_comb begin
    s_ready_d = (state_d == FILL);
    we0       = xfer && !wr_sel_q;
    we1       = xfer && wr_sel_q;
    waddr     = ADDR_W'((int'(row_q) + PAD) * OUT_W + int'(col_q) + PAD);
    wdata     = WIDTH'(pix_to_fixed(s_data, WIDTH, FRAC));
  end

  frame_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_bank0 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we0),
    .waddr(waddr),
    .wdata(wdata),
    .data (bank_data0)
  );

  frame_bank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_bank1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we1),
    .waddr(waddr),
    .wdata(wdata),
    .data (bank_data1)
  );

  assign frame_vec   = out_sel_q ? bank_data1 : bank_data0;
  assign frame_valid = frame_valid_q;
  assign s_ready     = s_ready_q;
  assign err_pulse   = err_pulse_q;
  assign drop_cnt    = drop_cnt_q;

endmodule
